// File: rtl/rrf_mt_pkg.sv
// Shared definitions for the multi-thread retirement register file:
// FSM state encoding, default port counts and the default entry width.
package rrf_mt_pkg;

   localparam int RRF_ALU_WIDTH = 32;

   localparam int RRF_NWR = 10;
   localparam int RRF_NRD = 11;

   typedef enum logic {
      RRF_CLEAR = 1'b0,
      RRF_RUN   = 1'b1
   } rrf_state_t;

endpackage

// File: rtl/rrf_wr_arb.sv
// Priority match/select over a set of write ports for one (thread, address)
// target. Used per storage entry as the write enable/data mux, and per read
// port as the bypass selector. Higher-numbered ports override lower ones.
module rrf_wr_arb
    import rrf_mt_pkg::*;
#(
    parameter int NP         = RRF_NWR,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int TW         = 1,
    parameter bit CMP_THREAD = 1'b1
) (
    input  logic [AW-1:0]    match_addr,
    input  logic [TW-1:0]    match_thread,
    input  logic [NP*AW-1:0] port_addr,
    input  logic [NP*DW-1:0] port_data,
    input  logic [NP-1:0]    port_en,
    input  logic [TW-1:0]    port_thread,
    output logic             hit,
    output logic [DW-1:0]    data
);

    logic thread_ok;

    // Scan ports in ascending order so the last (highest) match wins.
    always_comb begin
        hit       = 1'b0;
        data      = '0;
        thread_ok = !CMP_THREAD || (port_thread == match_thread);
        for (int p = 0; p < NP; p++) begin
            if (thread_ok && port_en[p] && (port_addr[p*AW +: AW] == match_addr)) begin
                hit  = 1'b1;
                data = port_data[p*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/rrf_mt.sv
// Parametrised multi-thread retirement register file. One storage bank per
// hardware thread, NWR prioritised write ports, NRD registered read ports
// with optional same-cycle write forwarding, and a post-reset sequencer that
// zeroes every entry before the file reports ready.
module rrf_mt
    import rrf_mt_pkg::*;
#(
    parameter int  DATA_WIDTH = RRF_ALU_WIDTH,
    parameter int  NREGS      = 32,
    parameter int  NTHREADS   = 2,
    parameter int  NWR        = RRF_NWR,
    parameter int  NRD        = RRF_NRD,
    parameter int  BYPASS     = 1,
    localparam int AW         = $clog2(NREGS),
    localparam int TW         = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     read_clkEn,
    input  logic [NRD*AW-1:0]        read_addr,
    input  logic [NRD-1:0]           read_oe,
    input  logic [TW-1:0]            read_thread,
    output logic [NRD*DATA_WIDTH-1:0] read_data,
    input  logic [NWR*AW-1:0]        write_addr,
    input  logic [NWR*DATA_WIDTH-1:0] write_data,
    input  logic [NWR-1:0]           write_wen,
    input  logic [TW-1:0]            write_thread,
    output logic                     ready
);

    localparam bit MULTI_THREAD = (NTHREADS > 1);

    logic [DATA_WIDTH-1:0] ram [NTHREADS][NREGS];

    rrf_state_t state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;

    logic [NRD*AW-1:0] addr_q;
    logic [NRD-1:0]    oe_q;
    logic [TW-1:0]     thread_q;
    logic [TW-1:0]     rd_bank;

    logic [NWR-1:0] wen_run;

    logic                  ent_we [NTHREADS][NREGS];
    logic [DATA_WIDTH-1:0] ent_wd [NTHREADS][NREGS];

    logic [NRD-1:0]        byp_hit;
    logic [DATA_WIDTH-1:0] byp_data [NRD];

    assign wen_run = write_wen & {NWR{state_q == RRF_RUN}};
    assign rd_bank = MULTI_THREAD ? thread_q : '0;
    assign ready   = (state_q == RRF_RUN);

    // FSM and clear index register; reset restarts clearing from entry 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RRF_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // CLEAR walks every entry once, then the file stays in RUN.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == RRF_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == AW'(NREGS - 1)) begin
                state_d = RRF_RUN;
            end
        end
    end

    // Read address/oe/thread capture, held while read_clkEn is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            oe_q     <= '0;
            thread_q <= '0;
        end else if (read_clkEn) begin
            addr_q   <= read_addr;
            oe_q     <= read_oe;
            thread_q <= read_thread;
        end
    end

    genvar gt, ge, gp;
    generate
        for (gt = 0; gt < NTHREADS; gt++) begin : g_bank
            for (ge = 0; ge < NREGS; ge++) begin : g_entry
                rrf_wr_arb #(
                    .NP         (NWR),
                    .AW         (AW),
                    .DW         (DATA_WIDTH),
                    .TW         (TW),
                    .CMP_THREAD (MULTI_THREAD)
                ) u_wr_arb (
                    .match_addr   (AW'(ge)),
                    .match_thread (TW'(gt)),
                    .port_addr    (write_addr),
                    .port_data    (write_data),
                    .port_en      (wen_run),
                    .port_thread  (write_thread),
                    .hit          (ent_we[gt][ge]),
                    .data         (ent_wd[gt][ge])
                );
            end
        end

        for (gp = 0; gp < NRD; gp++) begin : g_bypass
            rrf_wr_arb #(
                .NP         (NWR),
                .AW         (AW),
                .DW         (DATA_WIDTH),
                .TW         (TW),
                .CMP_THREAD (MULTI_THREAD)
            ) u_byp_arb (
                .match_addr   (addr_q[gp*AW +: AW]),
                .match_thread (thread_q),
                .port_addr    (write_addr),
                .port_data    (write_data),
                .port_en      (wen_run),
                .port_thread  (write_thread),
                .hit          (byp_hit[gp]),
                .data         (byp_data[gp])
            );
        end
    endgenerate

    // Storage update: clearing zeroes one entry in all banks, RUN applies writes.
    always_ff @(posedge clk) begin
        for (int t = 0; t < NTHREADS; t++) begin
            for (int e = 0; e < NREGS; e++) begin
                if (state_q == RRF_CLEAR) begin
                    if (clr_idx_q == AW'(e)) begin
                        ram[t][e] <= '0;
                    end
                end else if (ent_we[t][e]) begin
                    ram[t][e] <= ent_wd[t][e];
                end
            end
        end
    end

    // Read output: zero unless RUN and enabled; forwarded write data has priority.
    always_comb begin
        read_data = '0;
        for (int p = 0; p < NRD; p++) begin
            if ((state_q == RRF_RUN) && oe_q[p]) begin
                if ((BYPASS != 0) && byp_hit[p]) begin
                    read_data[p*DATA_WIDTH +: DATA_WIDTH] = byp_data[p];
                end else begin
                    read_data[p*DATA_WIDTH +: DATA_WIDTH] = ram[rd_bank][addr_q[p*AW +: AW]];
                end
            end
        end
    end

endmodule
